// File: rtl/lim_inc_if.sv
`default_nettype none
// ============================================================================
// Module   : lim_inc_if
// Purpose  : Digit/carry bundle between a stopwatch digit and its incrementor.
// Revision : 1.0
// ============================================================================
interface lim_inc_if #(
    parameter int W = 4
);
    logic [W-1:0] a;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic [W-1:0] sum_q;
    logic         co_q;

    modport master (
        output a, ci,
        input  sum, co, sum_q, co_q
    );

    modport slave (
        input  a, ci,
        output sum, co, sum_q, co_q
    );
endinterface
`default_nettype wire

// File: rtl/lim_inc.sv
`default_nettype none
// ============================================================================
// Module   : lim_inc
// Purpose  : Modulo-L digit incrementor with combinational and registered outs.
// Revision : 1.0
// ============================================================================
module lim_inc #(
    parameter int L = 11,
    parameter int W = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    lim_inc_if.slave   bus
);

    generate
        if ((L < 1) || (L > (2 ** W))) begin : g_bad_limit
            $fatal(1, "lim_inc: L=%0d outside 1..2**W (W=%0d)", L, W);
        end
    endgenerate

    // One extra bit so that a = 2**W-1 with ci = 1 cannot alias to zero.
    localparam logic [W:0] C_LIM = (W+1)'(L);

    logic [W:0]   w_t;
    logic         w_wrap;
    logic [W-1:0] sum_d;
    logic         co_d;
    logic [W-1:0] sum_q;
    logic         co_q;

    assign w_t    = {1'b0, bus.a} + {{W{1'b0}}, bus.ci};
    assign w_wrap = (w_t >= C_LIM);
    assign sum_d  = w_wrap ? '0 : w_t[W-1:0];
    assign co_d   = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            co_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            co_q  <= co_d;
        end
    end

    assign bus.sum   = sum_d;
    assign bus.co    = co_d;
    assign bus.sum_q = sum_q;
    assign bus.co_q  = co_q;

endmodule
`default_nettype wire

// File: tb/tb_lim_inc.sv
`default_nettype none
// ============================================================================
// Module   : tb_lim_inc
// Purpose  : Scoreboard bench for lim_inc with L=11, L=16 and L=1 instances.
// Revision : 1.0
// ============================================================================
module tb_lim_inc;

    logic       clk;
    logic       rst_n;
    logic [3:0] a_drv;
    logic       ci_drv;

    int n_chk;
    int n_err;
    int n_sweep;

    logic [4:0] sb_q[$];

    lim_inc_if #(.W(4)) bus11 ();
    lim_inc_if #(.W(4)) bus16 ();
    lim_inc_if #(.W(4)) bus1  ();

    assign bus11.a  = a_drv;
    assign bus11.ci = ci_drv;
    assign bus16.a  = a_drv;
    assign bus16.ci = ci_drv;
    assign bus1.a   = a_drv;
    assign bus1.ci  = ci_drv;

    lim_inc #(.L(11), .W(4)) u_dut11 (.clk(clk), .rst_n(rst_n), .bus(bus11.slave));
    lim_inc #(.L(16), .W(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    lim_inc #(.L(1),  .W(4)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rule: {sum, co}
    function automatic logic [4:0] model(input int lim, input logic [3:0] a, input logic ci);
        int t;
        t = int'(a) + int'(ci);
        if (t >= lim) return {4'd0, 1'b1};
        return {4'(t), 1'b0};
    endfunction

    task automatic pop_chk(input string tag, input logic [4:0] obs);
        logic [4:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {27'd0, obs}, {27'd0, e});
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic       ci;
        logic [4:0] exp;
    } dir_t;

    dir_t dirs[6];

    initial begin
        n_chk   = 0;
        n_err   = 0;
        n_sweep = 0;
        rst_n   = 1'b0;
        a_drv   = 4'd4;
        ci_drv  = 1'b1;

        // Reset held across a rising edge: registered outputs stay at zero
        @(posedge clk);
        #1;
        chk("rst_sum_q", {28'd0, bus11.sum_q}, 32'd0);
        chk("rst_co_q",  {31'd0, bus11.co_q},  32'd0);

        // Release and capture the wrap case a=10, ci=1
        @(negedge clk);
        rst_n  = 1'b1;
        a_drv  = 4'd10;
        ci_drv = 1'b1;
        sb_q.push_back(model(11, a_drv, ci_drv));
        @(posedge clk);
        #1;
        pop_chk("reg_wrap", {bus11.sum_q, bus11.co_q});

        // Non-wrapping capture a=4, ci=1
        @(negedge clk);
        a_drv  = 4'd4;
        ci_drv = 1'b1;
        sb_q.push_back(model(11, a_drv, ci_drv));
        @(posedge clk);
        #1;
        pop_chk("reg_inc", {bus11.sum_q, bus11.co_q});

        // Asynchronous assert mid-cycle clears before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sum_q", {28'd0, bus11.sum_q}, 32'd0);
        chk("async_co_q",  {31'd0, bus11.co_q},  32'd0);
        chk("async_comb_sum", {28'd0, bus11.sum}, 32'd5);

        @(negedge clk);
        rst_n  = 1'b1;
        a_drv  = 4'd12;
        ci_drv = 1'b0;
        sb_q.push_back(model(11, a_drv, ci_drv));
        @(posedge clk);
        #1;
        pop_chk("reg_after_rel", {bus11.sum_q, bus11.co_q});

        // Directed points for L=11
        dirs[0] = '{4'd4,  1'b1, {4'd5,  1'b0}};
        dirs[1] = '{4'd7,  1'b0, {4'd7,  1'b0}};
        dirs[2] = '{4'd10, 1'b1, {4'd0,  1'b1}};
        dirs[3] = '{4'd10, 1'b0, {4'd10, 1'b0}};
        dirs[4] = '{4'd12, 1'b0, {4'd0,  1'b1}};
        dirs[5] = '{4'd15, 1'b1, {4'd0,  1'b1}};
        for (int i = 0; i < 6; i++) begin
            a_drv  = dirs[i].a;
            ci_drv = dirs[i].ci;
            sb_q.push_back(dirs[i].exp);
            #5;
            pop_chk($sformatf("dir_a%0d_ci%0d", dirs[i].a, dirs[i].ci), {bus11.sum, bus11.co});
        end

        // Exhaustive sweep over all three limits
        for (int ai = 0; ai < 16; ai++) begin
            for (int ci = 0; ci < 2; ci++) begin
                a_drv  = 4'(ai);
                ci_drv = 1'(ci);
                sb_q.push_back(model(11, a_drv, ci_drv));
                sb_q.push_back(model(16, a_drv, ci_drv));
                sb_q.push_back(model(1,  a_drv, ci_drv));
                #5;
                pop_chk($sformatf("L11_a%0d_ci%0d", ai, ci), {bus11.sum, bus11.co});
                pop_chk($sformatf("L16_a%0d_ci%0d", ai, ci), {bus16.sum, bus16.co});
                pop_chk($sformatf("L1_a%0d_ci%0d",  ai, ci), {bus1.sum,  bus1.co});
                n_sweep++;
            end
        end
        chk("sweep_ran", 32'(n_sweep), 32'd32);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
